// File: rtl/serial_logic_proc_pkg.sv
// serial_logic_proc_pkg: shared encodings for the bit-serial logic processor.
// Carry-based ADD/SUB decoding exists only when SERIAL_LOGIC_PROC_ARITH_EN is defined.
package serial_logic_proc_pkg;

    typedef enum logic [3:0] {
        F_AND   = 4'd0,
        F_OR    = 4'd1,
        F_XOR   = 4'd2,
        F_ONES  = 4'd3,
        F_NAND  = 4'd4,
        F_NOR   = 4'd5,
        F_XNOR  = 4'd6,
        F_ZEROS = 4'd7,
        F_ADD   = 4'd8,
        F_SUB   = 4'd9
    } func_e;

    typedef enum logic [1:0] {R_KEEP, R_B_F, R_A_F, R_SWAP} route_e;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

    // Codes without a dedicated meaning fold onto the logic function in F[2:0].
    function automatic func_e decode_func(input logic [3:0] f);
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        if (f == F_ADD || f == F_SUB) return func_e'(f);
`endif
        return func_e'(f & 4'b0111);
    endfunction

endpackage

// File: rtl/serial_logic_slice.sv
// serial_logic_slice: combinational SHIFT_BITS-wide function unit.
// Carry in/out ports exist only when SERIAL_LOGIC_PROC_ARITH_EN is defined.
module serial_logic_slice
    import serial_logic_proc_pkg::*;
#(
    parameter int SHIFT_BITS = 1
) (
    input  logic [SHIFT_BITS-1:0] a_i,
    input  logic [SHIFT_BITS-1:0] b_i,
    input  func_e                 f_i,
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
    input  logic                  cin_i,
    output logic                  cout_o,
`endif
    output logic [SHIFT_BITS-1:0] f_o
);

    always_comb begin
        f_o = '0;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        cout_o = 1'b0;
`endif
        case (f_i)
            F_AND:   f_o = a_i & b_i;
            F_OR:    f_o = a_i | b_i;
            F_XOR:   f_o = a_i ^ b_i;
            F_ONES:  f_o = '1;
            F_NAND:  f_o = ~(a_i & b_i);
            F_NOR:   f_o = ~(a_i | b_i);
            F_XNOR:  f_o = ~(a_i ^ b_i);
            F_ZEROS: f_o = '0;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
            F_ADD:   {cout_o, f_o} = {1'b0, a_i} + {1'b0, b_i} + {{SHIFT_BITS{1'b0}}, cin_i};
            F_SUB:   {cout_o, f_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{SHIFT_BITS{1'b0}}, cin_i};
`endif
            default: f_o = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_proc.sv
// serial_logic_proc: bit-serial A/B logic processor with Busy/Done handshake.
// Define SERIAL_LOGIC_PROC_ARITH_EN to enable serial ADD/SUB with a carry flop between slices.
module serial_logic_proc
    import serial_logic_proc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_a_i,
    input  logic             load_b_i,
    input  logic             execute_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [3:0]       f_i,
    input  logic [1:0]       r_i,
    output logic [WIDTH-1:0] aval_o,
    output logic [WIDTH-1:0] bval_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cout_o
);

    localparam int N  = WIDTH / SHIFT_BITS;
    localparam int CW = $clog2(N) + 1;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    func_e                 f_q, f_d;
    route_e                r_q, r_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [SHIFT_BITS-1:0] sa, sb, sf, top_a, top_b;
    logic                  last;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
    logic                  carry_q, carry_d, cout_q, cout_d, slice_c;
`endif

    assign sa    = a_q[SHIFT_BITS-1:0];
    assign sb    = b_q[SHIFT_BITS-1:0];
    assign last  = cnt_q == CW'(N - 1);
    assign top_a = r_q == R_A_F ? sf : r_q == R_SWAP ? sb : sa;
    assign top_b = r_q == R_B_F ? sf : r_q == R_SWAP ? sa : sb;

    serial_logic_slice #(.SHIFT_BITS(SHIFT_BITS)) u_slice (
        .a_i   (sa),
        .b_i   (sb),
        .f_i   (f_q),
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        .cin_i (carry_q),
        .cout_o(slice_c),
`endif
        .f_o   (sf)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        carry_d = carry_q;
        cout_d  = cout_q;
`endif
        if (state_q != SHIFT) begin
            a_d = load_a_i ? din_i : a_q;
            b_d = load_b_i ? din_i : b_q;
        end
        case (state_q)
            IDLE: if (execute_i && !(load_a_i || load_b_i)) begin
                state_d = SHIFT;
                f_d     = decode_func(f_i);
                r_d     = route_e'(r_i);
                cnt_d   = '0;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
                carry_d = decode_func(f_i) == F_SUB;
                cout_d  = 1'b0;
`endif
            end
            SHIFT: begin
                // New slice enters at the top so the result ends up in original bit order.
                a_d   = WIDTH'({top_a, a_q} >> SHIFT_BITS);
                b_d   = WIDTH'({top_b, b_q} >> SHIFT_BITS);
                cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
                carry_d = slice_c;
                cout_d  = last ? (f_q == F_ADD || f_q == F_SUB) && slice_c : cout_q;
`endif
                if (last) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end
            HOLD:    state_d = execute_i ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == SHIFT;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= F_AND;
            r_q     <= R_KEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
            carry_q <= carry_d;
            cout_q  <= cout_d;
`endif
        end
    end

    assign aval_o = a_q;
    assign bval_o = b_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
    assign cout_o = cout_q;
`else
    assign cout_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_logic_proc.sv
// tb_serial_logic_proc: directed bench for W8/S1 and W16/S4 (plus W8/S2 with SERIAL_LOGIC_PROC_ARITH_EN).
// Instances share stimulus; a whole-word result model is checked against every instance each cycle.
module tb_serial_logic_proc;

    logic        clk = 1'b0;
    logic        rst = 1'b1, la = 1'b0, lb = 1'b0, ex = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  f = '0;
    logic [1:0]  r = '0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        bu8, dn8, co8, bu16, dn16, co16;

    serial_logic_proc #(.WIDTH(8), .SHIFT_BITS(1)) u8 (
        .clk_i(clk), .reset_i(rst), .load_a_i(la), .load_b_i(lb), .execute_i(ex),
        .din_i(din[7:0]), .f_i(f), .r_i(r), .aval_o(a8), .bval_o(b8),
        .busy_o(bu8), .done_o(dn8), .cout_o(co8));

    serial_logic_proc #(.WIDTH(16), .SHIFT_BITS(4)) u16 (
        .clk_i(clk), .reset_i(rst), .load_a_i(la), .load_b_i(lb), .execute_i(ex),
        .din_i(din), .f_i(f), .r_i(r), .aval_o(a16), .bval_o(b16),
        .busy_o(bu16), .done_o(dn16), .cout_o(co16));

    logic [15:0] da[3], db[3];
    logic        dbu[3], ddn[3], dco[3];

    assign da[0] = {8'h00, a8};
    assign db[0] = {8'h00, b8};
    assign dbu[0] = bu8;
    assign ddn[0] = dn8;
    assign dco[0] = co8;
    assign da[1] = a16;
    assign db[1] = b16;
    assign dbu[1] = bu16;
    assign ddn[1] = dn16;
    assign dco[1] = co16;

`ifdef SERIAL_LOGIC_PROC_ARITH_EN
    localparam int NI = 3;
    logic [7:0] a82, b82;
    logic       bu82, dn82, co82;

    serial_logic_proc #(.WIDTH(8), .SHIFT_BITS(2)) u82 (
        .clk_i(clk), .reset_i(rst), .load_a_i(la), .load_b_i(lb), .execute_i(ex),
        .din_i(din[7:0]), .f_i(f), .r_i(r), .aval_o(a82), .bval_o(b82),
        .busy_o(bu82), .done_o(dn82), .cout_o(co82));

    assign da[2] = {8'h00, a82};
    assign db[2] = {8'h00, b82};
    assign dbu[2] = bu82;
    assign ddn[2] = dn82;
    assign dco[2] = co82;
`else
    localparam int NI = 2;
    assign da[2] = '0;
    assign db[2] = '0;
    assign dbu[2] = 1'b0;
    assign ddn[2] = 1'b0;
    assign dco[2] = 1'b0;
`endif

    int wd[3] = '{8, 16, 8};
    int nn[3] = '{8, 4, 4};

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Whole-word reference: {carry, result} for one operation on full registers.
    function automatic logic [16:0] fn(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] fc, input int w);
        logic [15:0] m;
        logic [16:0] s;
        m = (w == 16) ? 16'hFFFF : 16'h00FF;
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        if (fc == 4'd8 || fc == 4'd9) begin
            s = {1'b0, a & m} + {1'b0, (fc == 4'd9 ? ~b : b) & m} + 17'(fc == 4'd9);
            return {s[w], s[15:0] & m};
        end
`endif
        case (fc[2:0])
            3'd0:    s = {1'b0, a & b};
            3'd1:    s = {1'b0, a | b};
            3'd2:    s = {1'b0, a ^ b};
            3'd3:    s = 17'h0FFFF;
            3'd4:    s = {1'b0, ~(a & b)};
            3'd5:    s = {1'b0, ~(a | b)};
            3'd6:    s = {1'b0, ~(a ^ b)};
            default: s = '0;
        endcase
        return {1'b0, s[15:0] & m};
    endfunction

    logic [15:0] ma[3], mb[3], pa[3], pb[3];
    logic        mbusy[3], mdone[3], mcout[3], pc[3];
    int          ph[3], cnt[3];
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic [16:0] rr;
        logic [15:0] m;
        if (rst) started = 1'b1;
        for (int i = 0; i < NI; i++) begin
            m = (wd[i] == 16) ? 16'hFFFF : 16'h00FF;
            if (rst) begin
                ma[i] = '0; mb[i] = '0; ph[i] = 0; cnt[i] = 0;
                mbusy[i] = 1'b0; mdone[i] = 1'b0; mcout[i] = 1'b0;
            end else begin
                mdone[i] = 1'b0;
                if (ph[i] == 0) begin
                    if (la || lb) begin
                        if (la) ma[i] = din & m;
                        if (lb) mb[i] = din & m;
                    end else if (ex) begin
                        rr = fn(ma[i], mb[i], f, wd[i]);
                        pa[i] = (r == 2'd2) ? rr[15:0] : (r == 2'd3) ? mb[i] : ma[i];
                        pb[i] = (r == 2'd1) ? rr[15:0] : (r == 2'd3) ? ma[i] : mb[i];
                        pc[i] = rr[16];
                        ph[i] = 1; cnt[i] = nn[i]; mbusy[i] = 1'b1; mcout[i] = 1'b0;
                    end
                end else if (ph[i] == 1) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        ph[i] = 2; ma[i] = pa[i]; mb[i] = pb[i]; mcout[i] = pc[i];
                        mbusy[i] = 1'b0; mdone[i] = 1'b1;
                    end
                end else begin
                    if (la) ma[i] = din & m;
                    if (lb) mb[i] = din & m;
                    if (!ex) ph[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("busy%0d", i), 17'(dbu[i]), 17'(mbusy[i]));
                chk($sformatf("done%0d", i), 17'(ddn[i]), 17'(mdone[i]));
                chk($sformatf("cout%0d", i), 17'(dco[i]), 17'(mcout[i]));
                if (!mbusy[i]) begin
                    chk($sformatf("aval%0d", i), 17'(da[i]), 17'(ma[i]));
                    chk($sformatf("bval%0d", i), 17'(db[i]), 17'(mb[i]));
                end
            end
        end
    end

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        la = 1'b1; din = a;
        @(negedge clk);
        la = 1'b0; lb = 1'b1; din = b;
        @(negedge clk);
        lb = 1'b0;
    endtask

    task automatic run(input logic [3:0] fc, input logic [1:0] rc,
                       output int b8c, output int b16c, output int d8c, output int d16c);
        f = fc; r = rc; ex = 1'b1;
        b8c = 0; b16c = 0; d8c = 0; d16c = 0;
        repeat (20) begin
            @(negedge clk);
            b8c += int'(bu8); b16c += int'(bu16); d8c += int'(dn8); d16c += int'(dn16);
        end
        ex = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int b8c, b16c, d8c, d16c;
        repeat (2) @(negedge clk);
        chk("rst_a8", 17'(a8), 17'h0);
        chk("rst_busy8", 17'(bu8), 17'h0);
        rst = 1'b0;

        load(16'h00A5, 16'h003C);
        run(4'd0, 2'd2, b8c, b16c, d8c, d16c);
        chk("and_busy_cycles8", 17'(b8c), 17'd8);
        chk("and_done_pulses8", 17'(d8c), 17'd1);
        chk("and_a8", 17'(a8), 17'h24);
        chk("and_b8", 17'(b8), 17'h3C);

        load(16'h0066, 16'h0055);
        run(4'd6, 2'd1, b8c, b16c, d8c, d16c);
        chk("xnor_b8", 17'(b8), 17'hCC);
        chk("xnor_a8", 17'(a8), 17'h66);
        run(4'd0, 2'd3, b8c, b16c, d8c, d16c);
        chk("swap_a8", 17'(a8), 17'hCC);
        chk("swap_b8", 17'(b8), 17'h66);

        load(16'h1234, 16'h0000);
        lb = 1'b1; din = 16'hFFFF; f = 4'd1; r = 2'd2; ex = 1'b1;
        @(negedge clk);
        chk("load_prio_busy16", 17'(bu16), 17'h0);
        lb = 1'b0;
        run(4'd1, 2'd2, b8c, b16c, d8c, d16c);
        chk("or_busy_cycles16", 17'(b16c), 17'd4);
        chk("or_done_pulses16", 17'(d16c), 17'd1);
        chk("or_a16", 17'(a16), 17'hFFFF);

        load(16'h000F, 16'h00F0);
        f = 4'd2; r = 2'd2; ex = 1'b1;
        repeat (2) @(negedge clk);
        la = 1'b1; din = 16'h0077;
        @(negedge clk);
        la = 1'b0;
        repeat (15) @(negedge clk);
        ex = 1'b0;
        @(negedge clk);
        chk("shift_load_ignored_a8", 17'(a8), 17'hFF);

        load(16'h00A5, 16'h003C);
        f = 4'd0; r = 2'd2; ex = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; ex = 1'b0;
        @(negedge clk);
        chk("midrst_a8", 17'(a8), 17'h0);
        chk("midrst_b8", 17'(b8), 17'h0);
        chk("midrst_busy8", 17'(bu8), 17'h0);
        rst = 1'b0;
        load(16'h00A5, 16'h003C);
        run(4'd0, 2'd2, b8c, b16c, d8c, d16c);
        chk("rerun_busy_cycles8", 17'(b8c), 17'd8);
        chk("rerun_a8", 17'(a8), 17'h24);

        load(16'h00F0, 16'h0025);
        run(4'd8, 2'd2, b8c, b16c, d8c, d16c);
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        chk("add_a82", 17'(a82), 17'h15);
        chk("add_cout82", 17'(co82), 17'h1);
`else
        chk("f8_as_and_a8", 17'(a8), 17'h20);
        chk("f8_cout8", 17'(co8), 17'h0);
`endif
        load(16'h0010, 16'h0001);
        run(4'd9, 2'd2, b8c, b16c, d8c, d16c);
`ifdef SERIAL_LOGIC_PROC_ARITH_EN
        chk("sub_a82", 17'(a82), 17'h0F);
        chk("sub_cout82", 17'(co82), 17'h1);
`else
        chk("f9_as_or_a8", 17'(a8), 17'h11);
        chk("f9_cout8", 17'(co8), 17'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
